// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply sequencer: ALU opcodes,
// sequencer state encoding and datapath width.
package alu_mul_sequencer_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  localparam logic [5:0] ALU_ADD = 6'b010000;
  localparam logic [5:0] ALU_SUB = 6'b010001;
  localparam logic [5:0] ALU_AND = 6'b010010;
  localparam logic [5:0] ALU_OR  = 6'b010011;
  localparam logic [5:0] ALU_XOR = 6'b010101;
  localparam logic [5:0] ALU_SLL = 6'b110000;
  localparam logic [5:0] ALU_SRL = 6'b110001;
  localparam logic [5:0] ALU_SLT = 6'b110011;
  localparam logic [5:0] ALU_MUL = 6'b010110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_SHIFT,
    S_FIX,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/response and shared-ALU signals of the multiply sequencer.
// slave: the sequencer; master: the execute stage (requester plus ALU).
interface alu_mul_sequencer_if;
  import alu_mul_sequencer_pkg::*;

  logic       start;
  word_t      op_a;
  word_t      op_b;
  logic       busy;
  logic       done;
  word_t      product;
  word_t      alu_a;
  word_t      alu_b;
  logic [5:0] alu_control;
  word_t      alu_result;

  modport slave (
    input  start, op_a, op_b, alu_result,
    output busy, done, product, alu_a, alu_b, alu_control
  );

  modport master (
    output start, op_a, op_b, alu_result,
    input  busy, done, product, alu_a, alu_b, alu_control
  );

endinterface

// File: rtl/alu_mul_sequencer.sv
// Signed 16-bit shift-add multiplier that time-shares the execute-stage ALU.
// Optional macro ALU_MUL_EARLY_EXIT_EN ends iteration once the multiplier is exhausted.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned ITER = 16
) (
  input logic                 clk,
  input logic                 reset,
  alu_mul_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  seq_state_e       state_q, state_d;
  word_t            a_q, a_d;
  word_t            b_q, b_d;
  logic             neg_q, neg_d;
  word_t            acc_q, acc_d;
  word_t            mplier_q, mplier_d;
  word_t            mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  word_t            product_q, product_d;

  word_t            alu_a, alu_b;
  logic [5:0]       alu_ctl;
  logic             busy, done;
  logic             last_iter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctl   = ALU_ADD;
    busy      = 1'b0;
    done      = 1'b0;
    last_iter = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          neg_d   = bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1];
          acc_d   = '0;
          count_d = '0;
          state_d = S_ABS_A;
        end
      end
      S_ABS_A: begin
        busy     = 1'b1;
        alu_ctl  = ALU_SUB;
        alu_b    = a_q;
        mplier_d = a_q[DATA_W-1] ? bus.alu_result : a_q;
        state_d  = S_ABS_B;
      end
      S_ABS_B: begin
        busy    = 1'b1;
        alu_ctl = ALU_SUB;
        alu_b   = b_q;
        mcand_d = b_q[DATA_W-1] ? bus.alu_result : b_q;
        state_d = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        // A zero bit still drives ADD 0+0 so the ALU sees a defined op every cycle.
        if (mplier_q[0]) begin
          alu_a = acc_q;
          alu_b = mcand_q;
          acc_d = bus.alu_result;
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        alu_ctl   = ALU_SLL;
        alu_a     = mcand_q;
        alu_b     = word_t'(1);
        mcand_d   = bus.alu_result;
        mplier_d  = mplier_q >> 1;
        count_d   = count_q + CNT_W'(1);
`ifdef ALU_MUL_EARLY_EXIT_EN
        last_iter = (count_q == CNT_LAST) || (mplier_d == '0);
`else
        last_iter = (count_q == CNT_LAST);
`endif
        state_d   = last_iter ? S_FIX : S_ITER;
      end
      S_FIX: begin
        busy = 1'b1;
        if (neg_q) begin
          alu_ctl = ALU_SUB;
          alu_b   = acc_q;
          acc_d   = bus.alu_result;
        end
        // Capture the sign-corrected value so product is valid in the DONE cycle.
        product_d = acc_d;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.product     = product_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_control = alu_ctl;

endmodule
